// File: rtl/led_pattern_gen.sv
// LED pattern generator: per-channel off / on / blink / breathe drive from a shared timebase.
// A prescaler divides enabled cycles into ticks; a phase bit toggles per tick for blink, and
// (optionally) a triangle duty ramp feeds a free-running PWM comparator for breathe.
// Optional feature: define LED_BREATHE_EN to build breathe mode; without it mode 11 blinks and
// the PWM counter, duty and ramp direction are not built.
module led_pattern_gen #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned DIV_W = 27,
  parameter int unsigned PWM_W = 8
) (
  input  logic                i_clk,
  input  logic                i_arst,
  input  logic                i_rst,
  input  logic                i_en,
  input  logic                i_load,
  input  logic [2*N_CH-1:0]   i_mode,
  input  logic [DIV_W-1:0]    i_div,
  output logic [N_CH-1:0]     o_led,
  output logic                o_tick
);

  localparam logic [1:0] ModeOff     = 2'b00;
  localparam logic [1:0] ModeOn      = 2'b01;
  localparam logic [1:0] ModeBlink   = 2'b10;
  localparam logic [1:0] ModeBreathe = 2'b11;

  // Reset synchroniser: asserts with i_arst, releases two clock edges later.
  logic [1:0] rst_sync_q;
  logic       arst_int;

  // Async-assert / sync-deassert reset stretcher.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      rst_sync_q <= 2'b11;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b0};
    end
  end

  assign arst_int = rst_sync_q[1];

  // Configuration and timebase state.
  logic [2*N_CH-1:0] mode_q, mode_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [DIV_W-1:0]  pre_cnt_q, pre_cnt_d;
  logic              phase_q, phase_d;
  logic              tick;
  logic [N_CH-1:0]   led_q, led_d;
  logic              tick_q;

  // Timebase next state: sync reset beats load, load beats counting (so no tick on load).
  always_comb begin
    mode_d    = mode_q;
    div_d     = div_q;
    pre_cnt_d = pre_cnt_q;
    phase_d   = phase_q;
    tick      = 1'b0;
    if (i_rst) begin
      mode_d    = '0;
      div_d     = '1;
      pre_cnt_d = '0;
      phase_d   = 1'b0;
    end else if (i_load) begin
      mode_d    = i_mode;
      div_d     = i_div;
      pre_cnt_d = '0;
    end else if (i_en) begin
      if (pre_cnt_q == div_q) begin
        pre_cnt_d = '0;
        tick      = 1'b1;
        phase_d   = ~phase_q;
      end else begin
        pre_cnt_d = pre_cnt_q + DIV_W'(1);
      end
    end
  end

`ifdef LED_BREATHE_EN
  typedef enum logic {DirUp, DirDown} dir_e;

  localparam logic [PWM_W-1:0] DutyTop = '1;

  logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [PWM_W-1:0] duty_q, duty_d;
  dir_e             dir_q, dir_d;

  // Breathe ramp: PWM counter runs free on enabled cycles, duty walks a triangle per tick.
  always_comb begin
    pwm_cnt_d = pwm_cnt_q;
    duty_d    = duty_q;
    dir_d     = dir_q;
    if (i_rst) begin
      pwm_cnt_d = '0;
      duty_d    = '0;
      dir_d     = DirUp;
    end else if (i_load) begin
      // Ramp position survives a reload; only the PWM counter restarts.
      pwm_cnt_d = '0;
    end else if (i_en) begin
      pwm_cnt_d = pwm_cnt_q + PWM_W'(1);
      if (tick) begin
        unique case (dir_q)
          DirUp: begin
            duty_d = duty_q + PWM_W'(1);
            if (duty_d == DutyTop) begin
              dir_d = DirDown;
            end
          end
          DirDown: begin
            duty_d = duty_q - PWM_W'(1);
            if (duty_d == '0) begin
              dir_d = DirUp;
            end
          end
          default: dir_d = DirUp;
        endcase
      end
    end
  end

  // Breathe state registers.
  always_ff @(posedge i_clk or posedge arst_int) begin
    if (arst_int) begin
      pwm_cnt_q <= '0;
      duty_q    <= '0;
      dir_q     <= DirUp;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      duty_q    <= duty_d;
      dir_q     <= dir_d;
    end
  end
`endif

  // LED drive decode from next-state values so a new mode shows the cycle after load.
  always_comb begin
    led_d = '0;
    for (int k = 0; k < int'(N_CH); k++) begin
      unique case (mode_d[2*k +: 2])
        ModeOff:     led_d[k] = 1'b0;
        ModeOn:      led_d[k] = 1'b1;
        ModeBlink:   led_d[k] = phase_d;
`ifdef LED_BREATHE_EN
        ModeBreathe: led_d[k] = (pwm_cnt_d < duty_d);
`else
        ModeBreathe: led_d[k] = phase_d;
`endif
        default:     led_d[k] = 1'b0;
      endcase
    end
  end

  // Timebase, configuration and output registers.
  always_ff @(posedge i_clk or posedge arst_int) begin
    if (arst_int) begin
      mode_q    <= '0;
      div_q     <= '1;
      pre_cnt_q <= '0;
      phase_q   <= 1'b0;
      led_q     <= '0;
      tick_q    <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      div_q     <= div_d;
      pre_cnt_q <= pre_cnt_d;
      phase_q   <= phase_d;
      led_q     <= led_d;
      tick_q    <= tick;
    end
  end

  assign o_led  = led_q;
  assign o_tick = tick_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen (N_CH=4, DIV_W=4, PWM_W=3): vector table plus
// hand sequences for async reset, mode 11 behaviour and (when built) breathe.
module tb_led_pattern_gen;

  logic       clk;
  logic       clk_on;
  logic       i_arst, i_rst, i_en, i_load;
  logic [7:0] i_mode;
  logic [3:0] i_div;
  logic [3:0] o_led;
  logic       o_tick;

  int n_checks = 0;
  int n_errors = 0;

  led_pattern_gen #(
    .N_CH (4),
    .DIV_W(4),
    .PWM_W(3)
  ) dut (
    .i_clk (clk),
    .i_arst(i_arst),
    .i_rst (i_rst),
    .i_en  (i_en),
    .i_load(i_load),
    .i_mode(i_mode),
    .i_div (i_div),
    .o_led (o_led),
    .o_tick(o_tick)
  );

  initial begin
    clk = 1'b0;
    wait (clk_on);
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, required finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       en;
    logic       load;
    logic       rst;
    logic [7:0] mode;
    logic [3:0] div;
    logic [3:0] led;
    logic       tick;
    string      name;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic en, input logic load, input logic rst,
                              input logic [7:0] mode, input logic [3:0] div,
                              input logic [3:0] led, input logic tick, input string name);
    vec_t v;
    v.en = en; v.load = load; v.rst = rst; v.mode = mode; v.div = div;
    v.led = led; v.tick = tick; v.name = name;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b, required %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_rst = 1'b0; i_en = 1'b0; i_load = 1'b0; i_mode = '0; i_div = '0;
  endtask

  localparam logic [7:0] MBlink = 8'b00_00_01_10;

  initial begin
    int waited;
    clk_on = 1'b0;
    i_arst = 1'b0;
    idle_inputs();

    // Async reset with no clock running.
    #2 i_arst = 1'b1;
    #1;
    check("arst_noclk_led", o_led, 4'b0000);
    check("arst_noclk_tick", {3'b0, o_tick}, 4'b0000);
    clk_on = 1'b1;
    repeat (3) step();
    i_arst = 1'b0;
    i_en   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("post_arst_led", o_led, 4'b0000);
      check("post_arst_tick", {3'b0, o_tick}, 4'b0000);
    end

    // Blink, freeze, divider 0, load priority, rst+load priority, on mode.
    add(1, 1, 0, MBlink, 4'd3, 4'b0010, 0, "load_blink");
    add(1, 0, 0, 0, 0, 4'b0010, 0, "blink_cnt1");
    add(1, 0, 0, 0, 0, 4'b0010, 0, "blink_cnt2");
    add(1, 0, 0, 0, 0, 4'b0010, 0, "blink_cnt3");
    add(1, 0, 0, 0, 0, 4'b0011, 1, "blink_tick1");
    add(1, 0, 0, 0, 0, 4'b0011, 0, "blink_hi1");
    add(1, 0, 0, 0, 0, 4'b0011, 0, "blink_hi2");
    add(1, 0, 0, 0, 0, 4'b0011, 0, "blink_hi3");
    add(1, 0, 0, 0, 0, 4'b0010, 1, "blink_tick2");
    add(1, 0, 0, 0, 0, 4'b0010, 0, "pre_freeze1");
    add(1, 0, 0, 0, 0, 4'b0010, 0, "pre_freeze2");
    for (int i = 0; i < 10; i++) add(0, 0, 0, 0, 0, 4'b0010, 0, "freeze");
    add(1, 0, 0, 0, 0, 4'b0010, 0, "resume_cnt");
    add(1, 0, 0, 0, 0, 4'b0011, 1, "resume_tick");
    add(1, 1, 0, MBlink, 4'd0, 4'b0011, 0, "load_beats_tick");
    add(1, 0, 0, 0, 0, 4'b0010, 1, "div0_tick1");
    add(1, 0, 0, 0, 0, 4'b0011, 1, "div0_tick2");
    add(1, 0, 0, 0, 0, 4'b0010, 1, "div0_tick3");
    add(0, 0, 0, 0, 0, 4'b0010, 0, "div0_freeze");
    add(1, 1, 1, 8'hFF, 4'd5, 4'b0000, 0, "rst_beats_load");
    for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 0, 4'b0000, 0, "after_rst_off");
    add(0, 1, 0, 8'b01_01_01_01, 4'd1, 4'b1111, 0, "load_on_noen");
    add(0, 0, 0, 0, 0, 4'b1111, 0, "on_noen");
    add(1, 0, 0, 0, 0, 4'b1111, 0, "on_cnt");
    add(1, 0, 0, 0, 0, 4'b1111, 1, "on_tick");

    foreach (vecs[i]) begin
      i_en   = vecs[i].en;
      i_load = vecs[i].load;
      i_rst  = vecs[i].rst;
      i_mode = vecs[i].mode;
      i_div  = vecs[i].div;
      step();
      check({vecs[i].name, "_led"}, o_led, vecs[i].led);
      check({vecs[i].name, "_tick"}, {3'b0, o_tick}, {3'b0, vecs[i].tick});
    end
    idle_inputs();

    // Async reset mid-blink while the LED is lit.
    i_en = 1'b1; i_load = 1'b1; i_mode = MBlink; i_div = 4'd0;
    step();
    i_load = 1'b0;
    waited = 0;
    while (o_led[0] !== 1'b1 && waited < 4) begin
      step();
      waited++;
    end
    check("blink_lit_seen", {3'b0, o_led[0]}, 4'b0001);
    #2 i_arst = 1'b1;
    #1;
    check("arst_mid_led", o_led, 4'b0000);
    check("arst_mid_tick", {3'b0, o_tick}, 4'b0000);
    step();
    i_arst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("arst_mid_hold", o_led, 4'b0000);
    end

`ifndef LED_BREATHE_EN
    // Mode 11 must track mode 10 exactly when breathe is not built.
    begin
      int  cnt;
      bit  ph;
      bit  tk;
      i_en = 1'b1; i_load = 1'b1; i_mode = 8'b00_00_11_10; i_div = 4'd1;
      step();
      i_load = 1'b0;
      check("m11_load_led", o_led, 4'b0000);
      cnt = 0; ph = 1'b0;
      for (int i = 0; i < 8; i++) begin
        step();
        tk = 1'b0;
        if (cnt == 1) begin cnt = 0; ph = ~ph; tk = 1'b1; end
        else cnt++;
        check("m11_as_blink_led", o_led, {2'b00, ph, ph});
        check("m11_as_blink_tick", {3'b0, o_tick}, {3'b0, tk});
      end
    end
`else
    // Breathe on channel 0 with a tick every cycle: triangle duty vs free PWM counter.
    begin
      int  pwm;
      int  duty;
      bit  up;
      i_en = 1'b1; i_load = 1'b1; i_mode = 8'b00_00_00_11; i_div = 4'd0;
      step();
      i_load = 1'b0;
      check("breathe_load_led", o_led, 4'b0000);
      pwm = 0; duty = 0; up = 1'b1;
      for (int i = 0; i < 32; i++) begin
        step();
        pwm = (pwm + 1) % 8;
        if (up) begin duty++; if (duty == 7) up = 1'b0; end
        else begin duty--; if (duty == 0) up = 1'b1; end
        check("breathe_led", o_led, (pwm < duty) ? 4'b0001 : 4'b0000);
        check("breathe_tick", {3'b0, o_tick}, 4'b0001);
      end
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/led_pattern_gen.md
LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

Interface
REQ-001 Parameter N_CH, default 4: number of LED channels, 1..16.
REQ-002 Parameter DIV_W, default 27: prescaler and divider width, 2..32.
REQ-003 Parameter PWM_W, default 8: PWM counter and duty width, 2..12.
REQ-004 i_clk  input  1  clock; all logic SHALL be on its rising edge.
REQ-005 i_arst  input  1  reset, asynchronous, active-high.
REQ-006 i_rst  input  1  synchronous reset, active-high; same effect as i_arst, applied at the next clock edge.
REQ-007 i_en  input  1  timebase enable; when low, the timebase freezes.
REQ-008 i_load  input  1  single-cycle pulse; latches i_mode and i_div.
REQ-009 i_mode  input  2*N_CH  per-channel mode (bits [2k+1:2k] = channel k): 00 off, 01 on, 10 blink, 11 breathe.
REQ-010 i_div  input  DIV_W  tick divider; tick period = i_div+1 enabled cycles.
REQ-011 o_led  output  N_CH  registered LED drive, one bit per channel.
REQ-012 o_tick  output  1  registered one-cycle pulse per timebase tick.

Function
REQ-013 The block SHALL hold the latched registers mode_q and div_q, which are written only on i_load.
REQ-014 Prescaler pre_cnt SHALL increment on each i_en=1 cycle; when pre_cnt==div_q, it SHALL wrap to 0 and assert tick.
REQ-015 With div_q==0, tick SHALL assert on every enabled cycle.
REQ-016 o_tick SHALL equal tick delayed by one register stage (registered in the same cycle that pre_cnt wraps).
REQ-017 A shared phase bit SHALL toggle on each tick.
REQ-018 Blink mode: o_led[k] SHALL equal phase, so the blink period is 2*(div_q+1) enabled cycles.
REQ-019 PWM counter pwm_cnt (PWM_W bits) SHALL increment on each enabled cycle and wrap freely.
REQ-020 Breathe mode: o_led[k] SHALL equal (pwm_cnt < duty).
REQ-021 Duty ramp on each tick:
- While dir is up, duty SHALL increment; on reaching 2^PWM_W-1, dir SHALL flip to down.
- While dir is down, duty SHALL decrement; on reaching 0, dir SHALL flip to up.
- The full triangle SHALL last 2*(2^PWM_W-1) ticks.
REQ-022 Off and on modes SHALL drive constant 0 and constant 1, independent of i_en.
REQ-023 Load timing:
- On i_load, mode_q and div_q SHALL update at that edge.
- pre_cnt and pwm_cnt SHALL clear at that edge.
- phase, duty and dir SHALL be retained.
- o_led SHALL reflect the new mode on the cycle after i_load.
REQ-024 Freeze: while i_en=0, pre_cnt, pwm_cnt, phase, duty and dir SHALL hold, o_tick SHALL be 0, and o_led SHALL hold its last value for blink and breathe channels.
REQ-025 When i_load and i_en are high in the same cycle, the load SHALL take precedence and no tick SHALL be generated that cycle.
REQ-026 When i_rst and i_load are high in the same cycle, i_rst SHALL take precedence.

Reset
REQ-027 On i_arst or i_rst, the block SHALL load these values:
- mode_q = all 00 (off), div_q = all ones
- pre_cnt = 0, pwm_cnt = 0, phase = 0
- duty = 0, dir = up
- o_led = 0, o_tick = 0
REQ-028 i_arst SHALL act immediately, with no clock required.
REQ-029 i_arst deassertion SHALL be synchronous to i_clk.
REQ-030 Reset mid-operation SHALL abandon any ramp or blink in progress without glitching o_led high.

Configuration
REQ-031 Macro LED_BREATHE_EN controls breathe-mode support.
REQ-032 With LED_BREATHE_EN defined, mode 11 SHALL be breathe per REQ-019 to REQ-021.
REQ-033 Without LED_BREATHE_EN:
- pwm_cnt, duty and dir SHALL not be synthesised.
- Mode 11 SHALL behave exactly as blink (10).
- All other behaviour SHALL be unchanged.

Verification (N_CH=4, DIV_W=4, PWM_W=3)
REQ-034 Reset: assert i_arst with no clock -> o_led=0000 and o_tick=0 immediately; both hold after release.
REQ-035 Blink: load i_mode=8'b00_00_01_10 with i_div=3, keep i_en=1 -> o_led[1]=1; o_tick pulses every 4 cycles; o_led[0] toggles every 4 cycles, first toggle 4 cycles after load.
REQ-036 Freeze and divider 0:
- Drop i_en for 10 cycles mid-period -> no o_tick pulses and o_led frozen; the remaining count resumes afterwards.
- Load i_div=0 -> o_tick every cycle.
REQ-037 Breathe (macro on): mode 11 with i_div=0 -> duty ramps 0..7..0 over 14 ticks; at duty=7, o_led is high 7 of every 8 cycles; at duty=0, o_led is constant low.
REQ-038 Priority: i_rst and i_load in the same cycle -> all outputs 0 and mode_q off. Without the macro: mode 11 waveform is identical to mode 10.
